ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline, directly downstream of the ALU-control decoder.
- Takes the 3-bit ALU control code, operands and forwarded control bits from decode, and registers them (ID/EX).
- Performs the ALU operation and registers the result plus flags (EX/MEM) for the memory stage.
- Two-register elastic pipeline with valid/ready handshakes on both sides and a synchronous flush for branch squash.

---
 rtl/ex_stage.sv | 156 +++++++++++++++
 tb/tb_ex_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
//
// Two-register elastic pipeline: stage 1 (ID/EX) captures the decoded op,
// the ALU works combinationally on stage-1 contents, and stage 2 (EX/MEM)
// captures the result, zero flag and forwarded control bits.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    synchronous squash of every in-flight op
//   id_valid / id_ready      decode-side handshake
//   id_aluc, id_srca/srcb    ALU control code and operands
//   id_wreg, id_regwrite,
//   id_memread, id_memwrite  control bits forwarded to MEM
//   ex_valid / ex_ready      MEM-side handshake
//   ex_result, ex_zero       ALU result and (result == 0)
//   ex_wreg, ex_regwrite,
//   ex_memread, ex_memwrite  forwarded control bits
//   ex_ovf                   signed-overflow flag (only with EX_OVERFLOW_TRAP_EN)
//
// Optional feature macro: EX_OVERFLOW_TRAP_EN. When defined, codes 001 (ADD)
// and 101 (SUB) flag signed overflow on ex_ovf and suppress ex_regwrite.

module ex_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [2:0]    id_aluc,
  input  logic [DW-1:0] id_srca,
  input  logic [DW-1:0] id_srcb,
  input  logic [RW-1:0] id_wreg,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  output logic          ex_valid,
  input  logic          ex_ready,
  output logic [DW-1:0] ex_result,
  output logic          ex_zero,
  output logic [RW-1:0] ex_wreg,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite
`ifdef EX_OVERFLOW_TRAP_EN
  ,
  output logic          ex_ovf
`endif
);

  // Stage 1 (ID/EX)
  logic          s1_valid;
  logic [2:0]    s1_aluc;
  logic [DW-1:0] s1_srca;
  logic [DW-1:0] s1_srcb;
  logic [RW-1:0] s1_wreg;
  logic          s1_regwrite;
  logic          s1_memread;
  logic          s1_memwrite;

  // Stage 2 (EX/MEM)
  logic          s2_valid;

  logic          s1_load;
  logic          s2_load;
  logic [DW-1:0] sum;
  logic [DW-1:0] diff;
  logic [DW-1:0] alu_res;
  logic          alu_ovf;

  assign s2_load  = s1_valid & (~s2_valid | ex_ready);
  assign id_ready = ~s1_valid | s2_load;
  assign s1_load  = id_valid & id_ready;
  assign ex_valid = s2_valid;

  assign sum  = s1_srca + s1_srcb;
  assign diff = s1_srca - s1_srcb;

  always_comb begin
    alu_res = '0;
    case (s1_aluc)
      3'b000, 3'b001: alu_res = sum;
      3'b010:         alu_res = s1_srca | s1_srcb;
      3'b100, 3'b101: alu_res = diff;
      3'b111:         alu_res = {{(DW-1){1'b0}}, ($signed(s1_srca) < $signed(s1_srcb))};
      default:        alu_res = s1_srca & s1_srcb;  // 011 and 110
    endcase
  end

`ifdef EX_OVERFLOW_TRAP_EN
  logic add_ovf;
  logic sub_ovf;
  // Same-sign operands giving a different-sign sum; for SUB, differing-sign
  // operands where the difference takes the sign of B.
  assign add_ovf = (s1_srca[DW-1] == s1_srcb[DW-1]) & (sum[DW-1] != s1_srca[DW-1]);
  assign sub_ovf = (s1_srca[DW-1] != s1_srcb[DW-1]) & (diff[DW-1] != s1_srca[DW-1]);
  assign alu_ovf = ((s1_aluc == 3'b001) & add_ovf) | ((s1_aluc == 3'b101) & sub_ovf);
`else
  assign alu_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_aluc     <= '0;
      s1_srca     <= '0;
      s1_srcb     <= '0;
      s1_wreg     <= '0;
      s1_regwrite <= 1'b0;
      s1_memread  <= 1'b0;
      s1_memwrite <= 1'b0;
      s2_valid    <= 1'b0;
      ex_result   <= '0;
      ex_zero     <= 1'b1;
      ex_wreg     <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
`ifdef EX_OVERFLOW_TRAP_EN
      ex_ovf      <= 1'b0;
`endif
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        s1_valid <= s1_load | (s1_valid & ~s2_load);
        s2_valid <= s2_load | (s2_valid & ~ex_ready);
      end
      // Data may update during a flush; the cleared valids make it don't-care.
      if (s1_load) begin
        s1_aluc     <= id_aluc;
        s1_srca     <= id_srca;
        s1_srcb     <= id_srcb;
        s1_wreg     <= id_wreg;
        s1_regwrite <= id_regwrite;
        s1_memread  <= id_memread;
        s1_memwrite <= id_memwrite;
      end
      if (s2_load) begin
        ex_result   <= alu_res;
        ex_zero     <= (alu_res == '0);
        ex_wreg     <= s1_wreg;
        ex_regwrite <= s1_regwrite & ~alu_ovf;
        ex_memread  <= s1_memread;
        ex_memwrite <= s1_memwrite;
`ifdef EX_OVERFLOW_TRAP_EN
        ex_ovf      <= alu_ovf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [2:0]  id_aluc;
  logic [31:0] id_srca;
  logic [31:0] id_srcb;
  logic [4:0]  id_wreg;
  logic        id_regwrite;
  logic        id_memread;
  logic        id_memwrite;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic        ex_zero;
  logic [4:0]  ex_wreg;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
`ifdef EX_OVERFLOW_TRAP_EN
  logic        ex_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_stage #(.DW(32), .RW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_aluc     (id_aluc),
    .id_srca     (id_srca),
    .id_srcb     (id_srcb),
    .id_wreg     (id_wreg),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_memwrite (id_memwrite),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_result   (ex_result),
    .ex_zero     (ex_zero),
    .ex_wreg     (ex_wreg),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_memwrite (ex_memwrite)
`ifdef EX_OVERFLOW_TRAP_EN
    ,
    .ex_ovf      (ex_ovf)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] aluc, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wreg, input logic rw, input logic mr, input logic mw);
    id_valid    = 1'b1;
    id_aluc     = aluc;
    id_srca     = a;
    id_srcb     = b;
    id_wreg     = wreg;
    id_regwrite = rw;
    id_memread  = mr;
    id_memwrite = mw;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    id_valid = 1'b0; id_aluc = 3'b000; id_srca = '0; id_srcb = '0;
    id_wreg = '0; id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0;

    // Reset then idle
    step(); step();
    rst = 1'b0;
    check_eq("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    check_eq("rst_ex_result", ex_result, 32'd0);
    check_eq("rst_ex_zero", {31'b0, ex_zero}, 32'd1);
    check_eq("rst_id_ready", {31'b0, id_ready}, 32'd1);
    check_eq("rst_ex_regwrite", {31'b0, ex_regwrite}, 32'd0);

    // Streaming, ex_ready=1
    offer(3'b001, 32'd5, 32'd7, 5'd1, 1'b1, 1'b0, 1'b0);
    step();
    offer(3'b101, 32'd3, 32'd3, 5'd2, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("stream_add_valid", {31'b0, ex_valid}, 32'd1);
    check_eq("stream_add", ex_result, 32'd12);
    check_eq("stream_add_wreg", {27'b0, ex_wreg}, 32'd1);
    offer(3'b010, 32'h0000_00F0, 32'h0000_000F, 5'd3, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("stream_sub", ex_result, 32'd0);
    check_eq("stream_sub_zero", {31'b0, ex_zero}, 32'd1);
    offer(3'b111, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("stream_or", ex_result, 32'h0000_00FF);
    check_eq("stream_or_zero", {31'b0, ex_zero}, 32'd0);
    check_eq("stream_id_ready", {31'b0, id_ready}, 32'd1);
    id_valid = 1'b0;
    step();
    check_eq("stream_slt", ex_result, 32'd1);
    check_eq("stream_slt_valid", {31'b0, ex_valid}, 32'd1);
    step();
    check_eq("stream_drain", {31'b0, ex_valid}, 32'd0);

    // Backpressure
    ex_ready = 1'b0;
    offer(3'b001, 32'd6, 32'd6, 5'd5, 1'b1, 1'b0, 1'b0);
    step();
    offer(3'b001, 32'd3, 32'd4, 5'd6, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("bp_full_ready", {31'b0, id_ready}, 32'd0);
    check_eq("bp_hold_valid", {31'b0, ex_valid}, 32'd1);
    check_eq("bp_hold_result", ex_result, 32'd12);
    offer(3'b001, 32'd4, 32'd5, 5'd7, 1'b1, 1'b0, 1'b0);
    step();
    step();
    check_eq("bp_still_ready", {31'b0, id_ready}, 32'd0);
    check_eq("bp_still_result", ex_result, 32'd12);
    check_eq("bp_still_wreg", {27'b0, ex_wreg}, 32'd5);
    ex_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", {31'b0, id_ready}, 32'd1);
    step();
    id_valid = 1'b0;
    check_eq("bp_second", ex_result, 32'd7);
    step();
    check_eq("bp_third", ex_result, 32'd9);
    check_eq("bp_third_valid", {31'b0, ex_valid}, 32'd1);
    step();
    check_eq("bp_empty", {31'b0, ex_valid}, 32'd0);

    // Flush with two in flight plus one offered
    ex_ready = 1'b0;
    offer(3'b001, 32'd10, 32'd10, 5'd8, 1'b1, 1'b0, 1'b0);
    step();
    offer(3'b001, 32'd11, 32'd11, 5'd9, 1'b1, 1'b0, 1'b0);
    step();
    offer(3'b001, 32'd12, 32'd12, 5'd10, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    id_valid = 1'b0;
    ex_ready = 1'b1;
    check_eq("flush_valid", {31'b0, ex_valid}, 32'd0);
    check_eq("flush_ready", {31'b0, id_ready}, 32'd1);
    step();
    check_eq("flush_nothing1", {31'b0, ex_valid}, 32'd0);
    step();
    check_eq("flush_nothing2", {31'b0, ex_valid}, 32'd0);

    // Flush discards an op whose handshake completes in the flush cycle
    offer(3'b001, 32'd1, 32'd1, 5'd11, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    id_valid = 1'b0;
    step();
    check_eq("flush_hs_drop", {31'b0, ex_valid}, 32'd0);

    // Next op flows normally
    offer(3'b001, 32'd2, 32'd2, 5'd12, 1'b1, 1'b0, 1'b0);
    step();
    id_valid = 1'b0;
    step();
    check_eq("post_flush_valid", {31'b0, ex_valid}, 32'd1);
    check_eq("post_flush_result", ex_result, 32'd4);
    step();

    // Branch compare and address add
    offer(3'b100, 32'h0000_1234, 32'h0000_1234, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    offer(3'b000, 32'h0000_1000, 32'hFFFF_FFFC, 5'd13, 1'b1, 1'b1, 1'b0);
    step();
    check_eq("beq_result", ex_result, 32'd0);
    check_eq("beq_zero", {31'b0, ex_zero}, 32'd1);
    id_valid = 1'b0;
    step();
    check_eq("addr_result", ex_result, 32'h0000_0FFC);
    check_eq("addr_regwrite", {31'b0, ex_regwrite}, 32'd1);
    check_eq("addr_memread", {31'b0, ex_memread}, 32'd1);
    check_eq("addr_memwrite", {31'b0, ex_memwrite}, 32'd0);
    check_eq("addr_wreg", {27'b0, ex_wreg}, 32'd13);

    // AND codes and signed SLT false case
    offer(3'b011, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd14, 1'b1, 1'b0, 1'b1);
    step();
    offer(3'b111, 32'd1, 32'hFFFF_FFFF, 5'd15, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("and_result", ex_result, 32'h0F00_0F00);
    check_eq("and_memwrite", {31'b0, ex_memwrite}, 32'd1);
    offer(3'b110, 32'h0000_00F0, 32'h0000_000F, 5'd16, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("slt_false", ex_result, 32'd0);
    id_valid = 1'b0;
    step();
    check_eq("and110_result", ex_result, 32'd0);
    check_eq("and110_zero", {31'b0, ex_zero}, 32'd1);

    // Signed overflow on ADD (001)
    offer(3'b001, 32'h7FFF_FFFF, 32'd1, 5'd17, 1'b1, 1'b0, 1'b0);
    step();
    offer(3'b101, 32'h8000_0000, 32'd1, 5'd18, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("ovf_add_result", ex_result, 32'h8000_0000);
`ifdef EX_OVERFLOW_TRAP_EN
    check_eq("ovf_add_flag", {31'b0, ex_ovf}, 32'd1);
    check_eq("ovf_add_regwrite", {31'b0, ex_regwrite}, 32'd0);
`else
    check_eq("ovf_add_regwrite", {31'b0, ex_regwrite}, 32'd1);
`endif
    offer(3'b000, 32'h7FFF_FFFF, 32'd1, 5'd19, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("ovf_sub_result", ex_result, 32'h7FFF_FFFF);
`ifdef EX_OVERFLOW_TRAP_EN
    check_eq("ovf_sub_flag", {31'b0, ex_ovf}, 32'd1);
    check_eq("ovf_sub_regwrite", {31'b0, ex_regwrite}, 32'd0);
`else
    check_eq("ovf_sub_regwrite", {31'b0, ex_regwrite}, 32'd1);
`endif
    id_valid = 1'b0;
    step();
    // Code 000 never traps
    check_eq("ovf_000_result", ex_result, 32'h8000_0000);
    check_eq("ovf_000_regwrite", {31'b0, ex_regwrite}, 32'd1);
`ifdef EX_OVERFLOW_TRAP_EN
    check_eq("ovf_000_flag", {31'b0, ex_ovf}, 32'd0);
`endif

    // Reset mid-operation drops in-flight ops
    ex_ready = 1'b0;
    offer(3'b001, 32'd20, 32'd22, 5'd20, 1'b1, 1'b1, 1'b1);
    step();
    offer(3'b001, 32'd30, 32'd30, 5'd21, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("midrst_pre_valid", {31'b0, ex_valid}, 32'd1);
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    id_valid = 1'b0;
    ex_ready = 1'b1;
    check_eq("midrst_valid", {31'b0, ex_valid}, 32'd0);
    check_eq("midrst_result", ex_result, 32'd0);
    check_eq("midrst_zero", {31'b0, ex_zero}, 32'd1);
    check_eq("midrst_memread", {31'b0, ex_memread}, 32'd0);
    step();
    check_eq("midrst_empty", {31'b0, ex_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
